// File: rtl/proc_pkg.sv
// Shared types and field positions for the fetch/execute sequencer.
package proc_pkg;

  localparam int unsigned PC_W_DEF    = 6;
  localparam int unsigned RF_AW_DEF   = 5;
  localparam int unsigned INSTR_W_DEF = 32;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned RD_MSB  = 25;
  localparam int unsigned RD_LSB  = 21;
  localparam int unsigned RS1_MSB = 20;
  localparam int unsigned RS1_LSB = 16;
  localparam int unsigned RS2_MSB = 15;
  localparam int unsigned RS2_LSB = 11;
  localparam int unsigned TGT_MSB = 5;
  localparam int unsigned TGT_LSB = 0;

  typedef enum logic [5:0] {
    OP_NOP    = 6'h00,
    OP_ALU    = 6'h01,
    OP_BRANCH = 6'h02,
    OP_JUMP   = 6'h03,
    OP_HALT   = 6'h3F
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_UPDATE,
    S_HALT
  } state_t;

endpackage

// File: rtl/pc_unit.sv
// Program counter: load or wrap-around increment when enabled.
module pc_unit #(
  parameter int unsigned PC_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_en,
  input  logic            i_load,
  input  logic [PC_W-1:0] i_target,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else if (i_en) begin
      r_pc <= i_load ? i_target : r_pc + PC_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_exec_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer, one instruction at a time.
// Optional fetch timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_exec_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter int unsigned RF_AW   = RF_AW_DEF
`ifdef FETCH_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 15
`endif
) (
  input  logic               clk,
  input  logic               clkreset,
  input  logic               run,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [RF_AW-1:0]   rf_ra,
  output logic [RF_AW-1:0]   rf_rb,
  output logic               rf_we,
  output logic [RF_AW-1:0]   rf_wa,
  output logic               ex_start,
  output logic [5:0]         ex_op,
  input  logic               ex_done,
  input  logic               ex_flag,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic               fetch_err
);

  state_t           r_state;
  opcode_t          r_op;
  logic [RF_AW-1:0] r_rd;
  logic [5:0]       r_tgt;
  logic             r_taken;
  logic             r_imem_req;
  logic [RF_AW-1:0] r_rf_ra;
  logic [RF_AW-1:0] r_rf_rb;
  logic             r_rf_we;
  logic [RF_AW-1:0] r_rf_wa;
  logic             r_ex_start;
  logic [5:0]       r_ex_op;
  logic             r_halted;

  logic [PC_W-1:0]  w_pc;
  logic             w_pc_en;
  logic             w_pc_load;
  logic             w_unused_bits;

  assign w_unused_bits = ^imem_data[RS2_LSB-1:TGT_MSB+1];

  assign w_pc_en   = (r_state == S_UPDATE);
  assign w_pc_load = (r_op == OP_JUMP) || ((r_op == OP_BRANCH) && r_taken);

  pc_unit #(.PC_W(PC_W)) u_pc (
    .clk      (clk),
    .rst_n    (clkreset),
    .i_en     (w_pc_en),
    .i_load   (w_pc_load),
    .i_target (r_tgt[PC_W-1:0]),
    .o_pc     (w_pc)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_fetch_err;
`endif

  always_ff @(posedge clk or negedge clkreset) begin
    if (!clkreset) begin
      r_state    <= S_IDLE;
      r_op       <= OP_NOP;
      r_rd       <= '0;
      r_tgt      <= '0;
      r_taken    <= 1'b0;
      r_imem_req <= 1'b0;
      r_rf_ra    <= '0;
      r_rf_rb    <= '0;
      r_rf_we    <= 1'b0;
      r_rf_wa    <= '0;
      r_ex_start <= 1'b0;
      r_ex_op    <= '0;
      r_halted   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      r_to_cnt    <= '0;
      r_fetch_err <= 1'b0;
`endif
    end else begin
      r_ex_start <= 1'b0;
      r_rf_we    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            r_to_cnt   <= '0;
`endif
          end
        end
        S_FETCH: begin
          // Register read addresses load with the instruction so they are valid in DECODE.
          if (imem_valid) begin
            r_state    <= S_DECODE;
            r_imem_req <= 1'b0;
            r_op       <= opcode_t'(imem_data[OPC_MSB:OPC_LSB]);
            r_rd       <= imem_data[RD_MSB:RD_LSB];
            r_tgt      <= imem_data[TGT_MSB:TGT_LSB];
            r_rf_ra    <= imem_data[RS1_MSB:RS1_LSB];
            r_rf_rb    <= imem_data[RS2_MSB:RS2_LSB];
          end
`ifdef FETCH_TIMEOUT_EN
          else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
            r_state     <= S_HALT;
            r_imem_req  <= 1'b0;
            r_halted    <= 1'b1;
            r_fetch_err <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
`endif
        end
        S_DECODE: begin
          case (r_op)
            OP_HALT: begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end
            OP_ALU, OP_BRANCH: begin
              r_state    <= S_EXECUTE;
              r_ex_start <= 1'b1;
              r_ex_op    <= r_op;
            end
            default: r_state <= S_UPDATE;
          endcase
        end
        S_EXECUTE: begin
          if (ex_done) begin
            if (r_op == OP_ALU) begin
              r_state <= S_WRITEBACK;
              r_rf_we <= 1'b1;
              r_rf_wa <= r_rd;
            end else begin
              r_state <= S_UPDATE;
              r_taken <= ex_flag;
            end
          end
        end
        S_WRITEBACK: r_state <= S_UPDATE;
        S_UPDATE: begin
          if (run) begin
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            r_to_cnt   <= '0;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req  = r_imem_req;
  assign imem_addr = w_pc;
  assign rf_ra     = r_rf_ra;
  assign rf_rb     = r_rf_rb;
  assign rf_we     = r_rf_we;
  assign rf_wa     = r_rf_wa;
  assign ex_start  = r_ex_start;
  assign ex_op     = r_ex_op;
  assign pc        = w_pc;
  assign halted    = r_halted;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = r_fetch_err;
`else
  assign fetch_err = 1'b0;
`endif

endmodule
